// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD write controller: FSM state codes,
// default timing, the command payload and the power-on init table (used with LCD_INIT_EN).
package lcd_pkg;

  localparam int unsigned T_SETUP_DEF     = 2;
  localparam int unsigned T_EN_DEF        = 12;
  localparam int unsigned T_HOLD_DEF      = 2;
  localparam int unsigned T_EXEC_DEF      = 2000;
  localparam int unsigned T_EXEC_LONG_DEF = 82000;
  localparam int unsigned T_PWR_DEF       = 750000;

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_SETUP = 3'd1;
  localparam logic [ST_W-1:0] ST_PULSE = 3'd2;
  localparam logic [ST_W-1:0] ST_HOLD  = 3'd3;
  localparam logic [ST_W-1:0] ST_WAIT  = 3'd4;
  localparam logic [ST_W-1:0] ST_PWR   = 3'd5;

  // Function set 8-bit/2-line, display on, clear, entry mode increment.
  localparam int unsigned INIT_LEN = 4;
  localparam logic [INIT_LEN-1:0][7:0] INIT_TABLE = {8'h06, 8'h01, 8'h0C, 8'h38};

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  // Clear display and return home need the long execution time.
  function automatic logic is_long_cmd(input lcd_cmd_t c);
    return !c.rs && (c.data == 8'h01 || c.data == 8'h02 || c.data == 8'h03);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter that holds at zero and flags it; paces every FSM phase.
module lcd_timer
  import lcd_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-style write-only LCD controller: one command per handshake, timed strobe.
// Optional power-on init sequence enabled by defining LCD_INIT_EN.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP     = T_SETUP_DEF,
  parameter int unsigned T_EN        = T_EN_DEF,
  parameter int unsigned T_HOLD      = T_HOLD_DEF,
  parameter int unsigned T_EXEC      = T_EXEC_DEF,
  parameter int unsigned T_EXEC_LONG = T_EXEC_LONG_DEF,
  parameter int unsigned T_PWR       = T_PWR_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on
);

  localparam int unsigned CNT_MAX = max2(max2(max2(T_SETUP, T_EN), max2(T_HOLD, T_EXEC)),
                                         max2(T_EXEC_LONG, T_PWR));
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

`ifdef LCD_INIT_EN
  localparam logic [ST_W-1:0] RST_STATE = ST_PWR;
`else
  localparam logic [ST_W-1:0] RST_STATE = ST_IDLE;
`endif

  logic [ST_W-1:0]  state, state_nxt;
  lcd_cmd_t         cmd_q, cmd_nxt;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic [CNT_W-1:0] exec_m1;

`ifdef LCD_INIT_EN
  logic [1:0] init_idx, init_idx_nxt;
  logic       init_busy, init_busy_nxt;
  logic       pwr_arm, pwr_arm_nxt;
`endif

  lcd_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero_c   (tmr_zero)
  );

  // State, latched command and strobe registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= RST_STATE;
      cmd_q  <= '0;
      lcd_en <= 1'b0;
      lcd_on <= 1'b0;
`ifdef LCD_INIT_EN
      init_idx  <= 2'd0;
      init_busy <= 1'b1;
      pwr_arm   <= 1'b1;
`endif
    end else begin
      state  <= state_nxt;
      cmd_q  <= cmd_nxt;
      lcd_en <= (state_nxt == ST_PULSE);
      lcd_on <= 1'b1;
`ifdef LCD_INIT_EN
      init_idx  <= init_idx_nxt;
      init_busy <= init_busy_nxt;
      pwr_arm   <= pwr_arm_nxt;
`endif
    end
  end

  // Next-state and timer-load decode; each phase loads N-1 and advances at zero
  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    exec_m1   = is_long_cmd(cmd_q) ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);
`ifdef LCD_INIT_EN
    init_idx_nxt  = init_idx;
    init_busy_nxt = init_busy;
    pwr_arm_nxt   = pwr_arm;
`endif
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_nxt.rs   = cmd_rs;
          cmd_nxt.data = cmd_data;
          state_nxt    = ST_SETUP;
          tmr_load     = 1'b1;
          tmr_val      = CNT_W'(T_SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_nxt = ST_PULSE;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(T_EN - 1);
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          state_nxt = ST_HOLD;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(T_HOLD - 1);
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          state_nxt = ST_WAIT;
          tmr_load  = 1'b1;
          tmr_val   = exec_m1;
        end
      end
      ST_WAIT: begin
        if (tmr_zero) begin
          state_nxt = ST_IDLE;
`ifdef LCD_INIT_EN
          if (init_busy) begin
            if (init_idx == 2'(INIT_LEN - 1)) begin
              init_busy_nxt = 1'b0;
            end else begin
              init_idx_nxt = init_idx + 2'd1;
              cmd_nxt      = '{rs: 1'b0, data: INIT_TABLE[init_idx + 2'd1]};
              state_nxt    = ST_SETUP;
              tmr_load     = 1'b1;
              tmr_val      = CNT_W'(T_SETUP - 1);
            end
          end
`endif
        end
      end
`ifdef LCD_INIT_EN
      // The first PWR cycle arms the counter, so the whole phase spans T_PWR cycles.
      ST_PWR: begin
        if ((pwr_arm && T_PWR <= 1) || (!pwr_arm && tmr_zero)) begin
          pwr_arm_nxt  = 1'b0;
          init_idx_nxt = 2'd0;
          cmd_nxt      = '{rs: 1'b0, data: INIT_TABLE[0]};
          state_nxt    = ST_SETUP;
          tmr_load     = 1'b1;
          tmr_val      = CNT_W'(T_SETUP - 1);
        end else if (pwr_arm) begin
          pwr_arm_nxt = 1'b0;
          tmr_load    = 1'b1;
          tmr_val     = CNT_W'(T_PWR - 2);
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state == ST_IDLE);
  assign lcd_rs    = cmd_q.rs;
  assign lcd_data  = cmd_q.data;
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Randomized and directed bench for lcd_ctrl against a transaction-timing reference model.
module tb_lcd_ctrl;

  localparam int unsigned TS  = 2;
  localparam int unsigned TE  = 4;
  localparam int unsigned TH  = 2;
  localparam int unsigned TX  = 10;
  localparam int unsigned TXL = 50;
  localparam int unsigned TP  = 20;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_on;

  lcd_ctrl #(
    .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TXL), .T_PWR(TP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_rs    (cmd_rs),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_on    (lcd_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_bad;

  // Reference model: cycles since the last accepted command and its busy length.
  int         m_k;
  int         m_busy;
  logic       m_rs;
  logic [7:0] m_data;
  logic       m_on;
  logic       m_pwr;
  logic [7:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int busy_of(input logic r, input logic [7:0] d);
    int ex;
    ex = (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? TXL : TX;
    return TS + TE + TH + ex;
  endfunction

  task automatic m_accept(input logic r, input logic [7:0] d);
    m_k    = 0;
    m_busy = busy_of(r, d);
    m_rs   = r;
    m_data = d;
  endtask

  function automatic logic m_ready();
    return !m_pwr && (m_q.size() == 0) && (m_k >= m_busy);
  endfunction

  // One clock: drive inputs, update the model at the edge, check all outputs on the falling edge.
  task automatic cycle(input logic v, input logic r, input logic [7:0] d);
    logic exp_en;
    cmd_valid = v;
    cmd_rs    = r;
    cmd_data  = d;
    @(posedge clk);
    if (!rst) begin
      m_k = 0; m_busy = 0; m_rs = 1'b0; m_data = 8'h00; m_on = 1'b0; m_pwr = 1'b0;
      m_q.delete();
`ifdef LCD_INIT_EN
      m_pwr  = 1'b1;
      m_busy = TP;
      m_q    = '{8'h38, 8'h0C, 8'h01, 8'h06};
`endif
    end else begin
      m_on = 1'b1;
      if (m_ready() && v) begin
        m_accept(r, d);
      end else begin
        m_k++;
        if (m_k >= m_busy && m_q.size() > 0) begin
          m_pwr = 1'b0;
          m_accept(1'b0, m_q.pop_front());
        end
      end
    end
    @(negedge clk);
    exp_en = !m_pwr && (m_k >= TS) && (m_k < TS + TE) && (m_k < m_busy);
    chk("en", 32'(lcd_en), 32'(exp_en));
    chk("ready", 32'(cmd_ready), 32'(m_ready()));
    chk("rs", 32'(lcd_rs), 32'(m_rs));
    chk("data", 32'(lcd_data), 32'(m_data));
    chk("on", 32'(lcd_on), 32'(m_on));
    chk("rw", 32'(lcd_rw), 32'd0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 400 && !cmd_ready; i++) cycle(1'b0, 1'b0, 8'h00);
    chk("ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  // Issue one command and measure busy length, strobe width/offset and strobe count.
  task automatic measure(input string tag, input logic r, input logic [7:0] d,
                         input int extra_at, input int exp_busy);
    int   k, en_cnt, first, rises;
    logic prev;
    wait_ready();
    cycle(1'b1, r, d);
    k = 0; en_cnt = 0; first = -1; rises = 0; prev = 1'b0;
    while (!cmd_ready && k < 400) begin
      if (lcd_en) begin
        en_cnt++;
        if (first < 0) first = k;
        if (!prev) rises++;
      end
      prev = lcd_en;
      if (k == extra_at) cycle(1'b1, 1'b1, 8'h42);
      else cycle(1'b0, r, d);
      k++;
    end
    chk({tag, "_busy"}, 32'(k), 32'(exp_busy));
    chk({tag, "_en_width"}, 32'(en_cnt), 32'd4);
    chk({tag, "_en_offset"}, 32'(first), 32'd2);
    chk({tag, "_en_pulses"}, 32'(rises), 32'd1);
    chk({tag, "_data_kept"}, 32'(lcd_data), 32'(d));
  endtask

  initial begin
    int low, hi;
    logic [7:0] d;
    n_total = 0; n_bad = 0;
    m_k = 0; m_busy = 0; m_rs = 1'b0; m_data = 8'h00; m_on = 1'b0; m_pwr = 1'b0;
    rst = 1'b0; cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'h55);
    chk("rst_on", 32'(lcd_on), 32'd0);
    chk("rst_data", 32'(lcd_data), 32'd0);
    rst = 1'b1;

`ifdef LCD_INIT_EN
    begin
      logic [7:0] seen[$];
      logic       prev;
      prev = 1'b0;
      for (int i = 0; i < 400 && !cmd_ready; i++) begin
        if (lcd_en && !prev) seen.push_back(lcd_data);
        prev = lcd_en;
        cycle(1'b1, 1'b1, 8'h77);
      end
      chk("init_count", 32'(seen.size()), 32'd4);
      if (seen.size() == 4) begin
        chk("init_0", 32'(seen[0]), 32'h38);
        chk("init_1", 32'(seen[1]), 32'h0C);
        chk("init_2", 32'(seen[2]), 32'h01);
        chk("init_3", 32'(seen[3]), 32'h06);
      end
    end
`endif

    measure("char41", 1'b1, 8'h41, -1, 18);
    measure("clear", 1'b0, 8'h01, -1, 58);
    measure("char01", 1'b1, 8'h01, -1, 18);
    measure("ignore42", 1'b1, 8'h41, 5, 18);

    // Reset on the second PULSE cycle
    wait_ready();
    cycle(1'b1, 1'b0, 8'h80);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h80);
    chk("pulse_before_rst", 32'(lcd_en), 32'd1);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 8'h00);
    chk("rst_drops_en", 32'(lcd_en), 32'd0);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 8'h00);
`ifndef LCD_INIT_EN
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);
`endif

    // cmd_valid held high: 18 busy cycles then acceptance on the single ready cycle
    wait_ready();
    low = 0; hi = 1;
    for (int i = 0; i < 80; i++) begin
      cycle(1'b1, 1'b1, 8'h41);
      if (cmd_ready) begin
        if (low > 0) chk("b2b_busy", 32'(low), 32'd18);
        low = 0; hi++;
      end else begin
        if (hi > 0) chk("b2b_ready_run", 32'(hi), 32'd1);
        hi = 0; low++;
      end
    end

    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), d);
    end
    rst = 1'b1;
    cycle(1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
